multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter: RETIRE_W, 16, width of the retired-instruction counter.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: op  input  6  instruction opcode field, from decoder.
REQ-005 SHALL have port: func  input  6  R-type function field, from decoder.
REQ-006 SHALL have port: zero  input  1  ALU zero flag.
REQ-007 SHALL have port: mem_ready  input  1  memory access complete.
REQ-008 SHALL have ports, all outputs, 1 bit each: pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal.
REQ-009 SHALL have ports: alu_src_b  output  2; alu_op  output  2 (00 add, 01 sub, 10 func-decode); pc_src  output  2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-010 SHALL have ports: state  output  4  current state; retired  output  RETIRE_W  instructions completed.

Function
REQ-011 SHALL implement a Moore FSM; all control outputs SHALL be decoded from the registered state only.
REQ-012 SHALL use state encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, WB_R=7, BRANCH=8, JUMP=9, EXEC_I=10, WB_I=11, ILLEGAL=12; codes 13-15 SHALL go to FETCH on the next cycle.
REQ-013 FETCH SHALL assert mem_read, ir_write, pc_write, alu_src_b=01, alu_op=00, pc_src=00, iord=0; next state DECODE.
REQ-014 DECODE SHALL assert alu_src_b=11, alu_op=00; next state by op: 000000->EXEC_R, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->EXEC_I, any other->ILLEGAL.
REQ-015 MEM_ADDR SHALL assert alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_RD when op=100011, else MEM_WR.
REQ-016 MEM_RD SHALL assert mem_read, iord=1; next MEM_WB. MEM_WB SHALL assert reg_write, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-017 MEM_WR SHALL assert mem_write, iord=1; next FETCH.
REQ-018 EXEC_R SHALL assert alu_src_a=1, alu_src_b=00, alu_op=10; next WB_R. WB_R SHALL assert reg_write, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-019 EXEC_I SHALL assert alu_src_a=1, alu_src_b=10, alu_op=00; next WB_I. WB_I SHALL assert reg_write, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-020 BRANCH SHALL assert alu_src_a=1, alu_op=01, pc_write_cond, pc_src=01; next FETCH; PC update is gated externally by zero.
REQ-021 JUMP SHALL assert pc_write, pc_src=10; next FETCH.
REQ-022 ILLEGAL SHALL assert illegal for exactly one cycle, write no register, memory or PC; next FETCH.
REQ-023 func SHALL be ignored by the FSM; it is forwarded only through alu_op=10 to the ALU decoder.
REQ-024 All outputs not named for a state SHALL be 0 in that state.
REQ-025 retired SHALL increment by 1 on the clock edge leaving MEM_WB, MEM_WR, WB_R, WB_I, BRANCH or JUMP; it SHALL wrap from all-ones to 0; ILLEGAL SHALL NOT increment it.
REQ-026 Instruction latency without wait states SHALL be: load 5, store 4, R-type 4, addi 4, branch 3, jump 3, illegal 3 cycles.

Reset
REQ-027 rst=1 SHALL immediately force state=FETCH and retired=0, independent of clk.
REQ-028 During reset all control outputs SHALL be 0, including the FETCH strobes; FETCH strobes SHALL assert from the first cycle after rst deasserts.
REQ-029 Reset asserted mid-instruction SHALL abandon it with no count and no further strobes.

Configuration
REQ-030 Macro MULTICYCLE_MEM_WAIT_EN defined: FETCH, MEM_RD and MEM_WR SHALL hold state, with strobes asserted, until a cycle with mem_ready=1, then advance; retired SHALL advance only on completion.
REQ-031 Macro absent: mem_ready SHALL be ignored and each memory state SHALL last exactly one cycle.

Verification
REQ-032 Reset release, op=100011 held: states 0,1,2,3,4,0; retired 0->1; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-033 op=000000, func=100000: states 0,1,6,7,0; alu_op=10 in state 6; reg_dst=1 in state 7.
REQ-034 op=000100, then op=000010: states 0,1,8,0,1,9,0; pc_write_cond=1 in 8, pc_src=10 in 9; retired +2.
REQ-035 op=111111: states 0,1,12,0; illegal high one cycle; retired unchanged.
REQ-036 With MULTICYCLE_MEM_WAIT_EN, op=101011, mem_ready low 3 cycles in MEM_WR: state stays 5 for 4 cycles with mem_write=1, then 0.
REQ-037 rst pulsed asynchronously in state 3: state=0 and retired=0 before the next clk edge.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (Moore) with retired-instruction counter.
// Optional memory wait states enabled by defining MULTICYCLE_MEM_WAIT_EN.
module multicycle_control #(
    parameter int RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          op,
    input  logic [5:0]          func,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                ir_write,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic                illegal,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_src,
    output logic [3:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    // state | meaning
    // 0  FETCH    | read instruction, PC += 4
    // 1  DECODE   | register read, branch target compute
    // 2  MEM_ADDR | effective address for lw/sw
    // 3  MEM_RD   | data memory read
    // 4  MEM_WB   | load write-back
    // 5  MEM_WR   | data memory write
    // 6  EXEC_R   | R-type ALU operation
    // 7  WB_R     | R-type write-back
    // 8  BRANCH   | beq compare, conditional PC write
    // 9  JUMP     | PC <- jump target
    // 10 EXEC_I   | addi ALU operation
    // 11 WB_I     | addi write-back
    // 12 ILLEGAL  | unsupported opcode, one-cycle flag
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC_R   = 4'd6;
    localparam logic [3:0] S_WB_R     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_EXEC_I   = 4'd10;
    localparam logic [3:0] S_WB_I     = 4'd11;
    localparam logic [3:0] S_ILLEGAL  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [RETIRE_W-1:0] RET_ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

    logic [3:0]          state_q, state_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                retire_evt;
    logic                mem_wait;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_wait = ~mem_ready;
    logic unused_inputs;
    assign unused_inputs = ^{func, zero};
`else
    assign mem_wait = 1'b0;
    logic unused_inputs;
    assign unused_inputs = ^{func, zero, mem_ready};
`endif

    always_comb begin
        state_d    = S_FETCH;
        retire_evt = 1'b0;
        case (state_q)
            S_FETCH:    state_d = mem_wait ? S_FETCH : S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_EXEC_I;
                    default:       state_d = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = mem_wait ? S_MEM_RD : S_MEM_WB;
            S_MEM_WB:   retire_evt = 1'b1;
            S_MEM_WR: begin
                state_d    = mem_wait ? S_MEM_WR : S_FETCH;
                retire_evt = ~mem_wait;
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_WB_R:     retire_evt = 1'b1;
            S_BRANCH:   retire_evt = 1'b1;
            S_JUMP:     retire_evt = 1'b1;
            S_EXEC_I:   state_d = S_WB_I;
            S_WB_I:     retire_evt = 1'b1;
            default:    state_d = S_FETCH;
        endcase
        retired_d = retire_evt ? retired_q + RET_ONE : retired_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    logic       pc_write_dec, pc_write_cond_dec, ir_write_dec, iord_dec;
    logic       mem_read_dec, mem_write_dec, reg_write_dec, reg_dst_dec;
    logic       mem_to_reg_dec, alu_src_a_dec, illegal_dec;
    logic [1:0] alu_src_b_dec, alu_op_dec, pc_src_dec;

    always_comb begin
        pc_write_dec      = 1'b0;
        pc_write_cond_dec = 1'b0;
        ir_write_dec      = 1'b0;
        iord_dec          = 1'b0;
        mem_read_dec      = 1'b0;
        mem_write_dec     = 1'b0;
        reg_write_dec     = 1'b0;
        reg_dst_dec       = 1'b0;
        mem_to_reg_dec    = 1'b0;
        alu_src_a_dec     = 1'b0;
        illegal_dec       = 1'b0;
        alu_src_b_dec     = 2'b00;
        alu_op_dec        = 2'b00;
        pc_src_dec        = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_dec  = 1'b1;
                ir_write_dec  = 1'b1;
                pc_write_dec  = 1'b1;
                alu_src_b_dec = 2'b01;
            end
            S_DECODE:   alu_src_b_dec = 2'b11;
            S_MEM_ADDR, S_EXEC_I: begin
                alu_src_a_dec = 1'b1;
                alu_src_b_dec = 2'b10;
            end
            S_MEM_RD: begin
                mem_read_dec = 1'b1;
                iord_dec     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_dec  = 1'b1;
                mem_to_reg_dec = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_dec = 1'b1;
                iord_dec      = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_dec = 1'b1;
                alu_op_dec    = 2'b10;
            end
            S_WB_R: begin
                reg_write_dec = 1'b1;
                reg_dst_dec   = 1'b1;
            end
            S_WB_I:     reg_write_dec = 1'b1;
            S_BRANCH: begin
                alu_src_a_dec     = 1'b1;
                alu_op_dec        = 2'b01;
                pc_write_cond_dec = 1'b1;
                pc_src_dec        = 2'b01;
            end
            S_JUMP: begin
                pc_write_dec = 1'b1;
                pc_src_dec   = 2'b10;
            end
            S_ILLEGAL:  illegal_dec = 1'b1;
            default: ;
        endcase
    end

    // Reset masks the FETCH decode so no strobe leaks while rst is high.
    assign pc_write      = pc_write_dec      & ~rst;
    assign pc_write_cond = pc_write_cond_dec & ~rst;
    assign ir_write      = ir_write_dec      & ~rst;
    assign iord          = iord_dec          & ~rst;
    assign mem_read      = mem_read_dec      & ~rst;
    assign mem_write     = mem_write_dec     & ~rst;
    assign reg_write     = reg_write_dec     & ~rst;
    assign reg_dst       = reg_dst_dec       & ~rst;
    assign mem_to_reg    = mem_to_reg_dec    & ~rst;
    assign alu_src_a     = alu_src_a_dec     & ~rst;
    assign illegal       = illegal_dec       & ~rst;
    assign alu_src_b     = rst ? 2'b00 : alu_src_b_dec;
    assign alu_op        = rst ? 2'b00 : alu_op_dec;
    assign pc_src        = rst ? 2'b00 : pc_src_dec;
    assign state         = state_q;
    assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver plans per-cycle expectations
// from an instruction-path model, monitor compares on every falling edge.
module tb_multicycle_control;

    localparam int RW = 4;
`ifdef MULTICYCLE_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    op, func;
    logic          zero, mem_ready;
    logic          pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write;
    logic          reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0]    alu_src_b, alu_op, pc_src;
    logic [3:0]    state;
    logic [RW-1:0] retired;

    multicycle_control #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .illegal(illegal), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    logic [16:0] act_ctrl;
    assign act_ctrl = {pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
                       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal,
                       alu_src_b, alu_op, pc_src};

    typedef struct {
        logic [3:0]    st;
        logic [16:0]   ctrl;
        logic [RW-1:0] ret;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [RW-1:0] exp_ret = '0;

    // pw pwc irw iord mrd mwr rw rdst m2r asa ill | asb aop psrc
    function automatic logic [16:0] ctrl_of(input int s);
        case (s)
            0:       return 17'b1_0_1_0_1_0_0_0_0_0_0_01_00_00;
            1:       return 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
            2, 10:   return 17'b0_0_0_0_0_0_0_0_0_1_0_10_00_00;
            3:       return 17'b0_0_0_1_1_0_0_0_0_0_0_00_00_00;
            4:       return 17'b0_0_0_0_0_0_1_0_1_0_0_00_00_00;
            5:       return 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
            6:       return 17'b0_0_0_0_0_0_0_0_0_1_0_00_10_00;
            7:       return 17'b0_0_0_0_0_0_1_1_0_0_0_00_00_00;
            8:       return 17'b0_1_0_0_0_0_0_0_0_1_0_00_01_01;
            9:       return 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;
            11:      return 17'b0_0_0_0_0_0_1_0_0_0_0_00_00_00;
            12:      return 17'b0_0_0_0_0_0_0_0_0_0_1_00_00_00;
            default: return 17'b0;
        endcase
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return o == 6'h00 || o == 6'h23 || o == 6'h2b || o == 6'h04 || o == 6'h02 || o == 6'h08;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cycle is an output cycle for a Moore controller.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("state", int'(state), int'(e.st));
            check("ctrl", int'(act_ctrl), int'(e.ctrl));
            check("retired", int'(retired), int'(e.ret));
        end
    end

    // One expected cycle; called just after a rising edge.
    task automatic step(input int s, input logic rdy);
        exp_t e;
        mem_ready = rdy;
        zero      = 1'($urandom);
        e.st = 4'(s); e.ctrl = ctrl_of(s); e.ret = exp_ret;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic do_phase(input int s, input int wreq);
        int nw;
        if (WAIT_EN && (s == 0 || s == 3 || s == 5)) begin
            nw = (wreq >= 0) ? wreq : int'($urandom_range(0, 3));
            repeat (nw) step(s, 1'b0);
            step(s, 1'b1);
        end else begin
            step(s, 1'($urandom));
        end
    endtask

    // Instruction path: fetch, decode, then class-specific execution phases.
    task automatic run_instr(input logic [5:0] o, input int wreq);
        int p[5];
        int n;
        op   = o;
        func = 6'($urandom);
        p[0] = 0; p[1] = 1;
        case (o)
            6'h23:   begin p[2] = 2; p[3] = 3; p[4] = 4; n = 5; end
            6'h2b:   begin p[2] = 2; p[3] = 5; n = 4; end
            6'h00:   begin p[2] = 6; p[3] = 7; n = 4; end
            6'h08:   begin p[2] = 10; p[3] = 11; n = 4; end
            6'h04:   begin p[2] = 8; n = 3; end
            6'h02:   begin p[2] = 9; n = 3; end
            default: begin p[2] = 12; n = 3; end
        endcase
        for (int i = 0; i < n; i++) do_phase(p[i], wreq);
        if (is_legal(o)) exp_ret = exp_ret + 1'b1;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] legal_ops[6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
        logic [5:0] o;
        if ($urandom_range(0, 7) != 0) return legal_ops[$urandom_range(0, 5)];
        do o = 6'($urandom_range(0, 63)); while (is_legal(o));
        return o;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; op = 6'h23; func = '0; zero = 1'b0; mem_ready = 1'b0;
        #3;
        check("rst_state", int'(state), 0);
        check("rst_retired", int'(retired), 0);
        check("rst_ctrl", int'(act_ctrl), 0);
        @(posedge clk); #1;
        check("rst_ctrl_clocked", int'(act_ctrl), 0);
        rst = 1'b0;

        run_instr(6'h23, -1);
        run_instr(6'h00, -1);
        func = 6'b100000;
        run_instr(6'h04, -1);
        run_instr(6'h02, -1);
        run_instr(6'h3f, -1);
        run_instr(6'h08, -1);
        run_instr(6'h2b, 3);
        for (int k = 0; k < 250; k++) run_instr(rand_op(), -1);

        // Asynchronous reset in the middle of a load (MEM_RD).
        if (exp_ret == '0) run_instr(6'h02, -1);
        op = 6'h23;
        do_phase(0, 0); do_phase(1, 0); do_phase(2, 0);
        begin
            exp_t e;
            mem_ready = 1'b1;
            e.st = 4'd3; e.ctrl = ctrl_of(3); e.ret = exp_ret;
            exp_q.push_back(e);
        end
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", int'(state), 0);
        check("async_rst_retired", int'(retired), 0);
        check("async_rst_ctrl", int'(act_ctrl), 0);
        @(posedge clk); #1;
        check("held_rst_ctrl", int'(act_ctrl), 0);
        check("held_rst_state", int'(state), 0);
        rst = 1'b0;
        exp_ret = '0;
        for (int k = 0; k < 40; k++) run_instr(rand_op(), -1);

        begin
            int guard = 0;
            while (exp_q.size() > 0 && guard < 10) begin
                @(negedge clk); #1;
                guard++;
            end
            check("queue_drained", exp_q.size(), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
